// File: rtl/alien_march_ctrl.sv
// Fleet march timing and position for the alien wave: paces step_en, applies moves, tracks kills.
// Latency: step_en is combinational from state and tick count; a move lands two edges after its step_en.
// Backpressure: none; pause freezes the tick count, and start overrides everything else.
//
// Ports:
//   clk, reset (async, active-low)  - clock and reset
//   start, pause, alien_killed      - wave control: start/restart pulse, freeze level, kill pulse
//   motion[2:0]                     - one-hot move from the motion FSM (100 right, 010 down, 001 left)
//   step_en                         - one-cycle step request to the motion FSM
//   can_left, can_right             - next horizontal step would stay inside the playfield
//   fleet_x, fleet_y                - fleet top-left position
//   alive_cnt                       - aliens remaining
//   wave_clear, invaded             - end-of-wave status levels, held until start
module alien_march_ctrl #(
  parameter int          NUM_ALIENS  = 55,
  parameter logic [15:0] BASE_PERIOD = 16'd50000,
  parameter logic [15:0] MIN_PERIOD  = 16'd2000,
  parameter logic [15:0] PERIOD_DEC  = 16'd800,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 639,
  parameter int          FLEET_W     = 352,
  parameter int          FLEET_H     = 128,
  parameter int          STEP_X      = 8,
  parameter int          STEP_Y      = 16,
  parameter int          X_START     = 16,
  parameter int          Y_START     = 32,
  parameter int          Y_INVADE    = 416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       alien_killed,
  input  logic [2:0] motion,
  output logic       step_en,
  output logic       can_left,
  output logic       can_right,
  output logic [9:0] fleet_x,
  output logic [9:0] fleet_y,
  output logic [5:0] alive_cnt,
  output logic       wave_clear,
  output logic       invaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_CLEAR,
    S_INVADED
  } state_t;

  state_t      r_state;
  logic [15:0] r_tick;
  logic [15:0] r_period;
  logic        r_move_apply;
  logic [9:0]  r_fleet_x;
  logic [9:0]  r_fleet_y;
  logic [5:0]  r_alive;
  logic        r_wave_clear;
  logic        r_invaded;

  logic        w_step_en;
  logic        w_kill_ok;
  logic        w_invade_hit;
  logic [15:0] w_period_dec;

  // tick+1 >= period avoids the underflow of period-1 at 17 bits.
  assign w_step_en = (r_state == S_RUN) &&
                     (({1'b0, r_tick} + 17'd1) >= {1'b0, r_period});

  // Boundary checks at 11 bits so fleet_x plus the box width cannot wrap.
  assign can_right = (({1'b0, r_fleet_x} + 11'(FLEET_W + STEP_X - 1)) <= 11'(X_MAX));
  assign can_left  = ({1'b0, r_fleet_x} >= 11'(X_MIN + STEP_X));

  // Invasion is judged on the row the fleet is moving down from.
  assign w_invade_hit = (({1'b0, r_fleet_y} + 11'(FLEET_H)) >= 11'(Y_INVADE));

  assign w_kill_ok = alien_killed && (r_state != S_IDLE) && (r_alive != 6'd0);

  // Saturating speed-up: never drop below MIN_PERIOD, never underflow.
  assign w_period_dec = ({1'b0, r_period} >= ({1'b0, MIN_PERIOD} + {1'b0, PERIOD_DEC}))
                        ? (r_period - PERIOD_DEC) : MIN_PERIOD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_tick       <= 16'd0;
      r_period     <= BASE_PERIOD;
      r_move_apply <= 1'b0;
      r_fleet_x    <= 10'(X_START);
      r_fleet_y    <= 10'(Y_START);
      r_alive      <= 6'(NUM_ALIENS);
      r_wave_clear <= 1'b0;
      r_invaded    <= 1'b0;
    end else if (start) begin
      // A restart also drops any move still pending from the previous wave.
      r_state      <= S_RUN;
      r_tick       <= 16'd0;
      r_period     <= BASE_PERIOD;
      r_move_apply <= 1'b0;
      r_fleet_x    <= 10'(X_START);
      r_fleet_y    <= 10'(Y_START);
      r_alive      <= 6'(NUM_ALIENS);
      r_wave_clear <= 1'b0;
      r_invaded    <= 1'b0;
    end else begin
      r_move_apply <= w_step_en;

      case (r_state)
        S_RUN: begin
          r_tick <= w_step_en ? 16'd0 : (r_tick + 16'd1);
          if (pause) r_state <= S_PAUSED;
        end
        S_PAUSED: begin
          if (!pause) r_state <= S_RUN;
        end
        default: ;
      endcase

      // A step granted in the cycle the last alien died is dropped once CLEAR is entered.
      if (r_move_apply && (r_state != S_CLEAR)) begin
        case (motion)
          3'b100: r_fleet_x <= r_fleet_x + 10'(STEP_X);
          3'b001: r_fleet_x <= r_fleet_x - 10'(STEP_X);
          3'b010: begin
            r_fleet_y <= r_fleet_y + 10'(STEP_Y);
            if (w_invade_hit) begin
              r_state   <= S_INVADED;
              r_invaded <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Kill is handled last so that clearing the wave wins over any other transition.
      if (w_kill_ok) begin
        r_alive  <= r_alive - 6'd1;
        r_period <= w_period_dec;
        if (r_alive == 6'd1) begin
          r_state      <= S_CLEAR;
          r_wave_clear <= 1'b1;
        end
      end
    end
  end

  assign step_en    = w_step_en;
  assign fleet_x    = r_fleet_x;
  assign fleet_y    = r_fleet_y;
  assign alive_cnt  = r_alive;
  assign wave_clear = r_wave_clear;
  assign invaded    = r_invaded;

endmodule
